// File: rtl/mul_div_pkg.sv
// Shared definitions for the Execute-stage multiply/divide unit.
//   F3_*     : RV32M funct3 encodings
//   state_e  : sequencer states of the iterative unit
package mul_div_pkg;

   localparam logic [2:0] F3_MUL    = 3'b000;
   localparam logic [2:0] F3_MULH   = 3'b001;
   localparam logic [2:0] F3_MULHSU = 3'b010;
   localparam logic [2:0] F3_MULHU  = 3'b011;
   localparam logic [2:0] F3_DIV    = 3'b100;
   localparam logic [2:0] F3_DIVU   = 3'b101;
   localparam logic [2:0] F3_REM    = 3'b110;
   localparam logic [2:0] F3_REMU   = 3'b111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ITER = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage

// File: rtl/mul_div_step.sv
// One combinational iteration of the magnitude datapath.
//   is_div_i : 1 = restoring divide step, 0 = shift-add multiply step
//   acc_i    : {hi, lo} accumulator; multiply {partial, multiplier}, divide {remainder, dividend/quotient}
//   oper_i   : multiplicand magnitude (multiply) or divisor magnitude (divide)
//   acc_o    : accumulator after this iteration
module mul_div_step #(
   parameter int unsigned XLEN = 32
) (
   input  logic              is_div_i,
   input  logic [2*XLEN-1:0] acc_i,
   input  logic [XLEN-1:0]   oper_i,
   output logic [2*XLEN-1:0] acc_o
);

   logic [XLEN:0]   sum;
   logic [XLEN:0]   shifted;
   logic [XLEN-1:0] diff;
   logic            fits;

   always_comb begin
      // Multiply: add multiplicand on a set LSB, then shift the whole pair right (carry enters at top)
      sum     = {1'b0, acc_i[2*XLEN-1:XLEN]} + (acc_i[0] ? {1'b0, oper_i} : '0);
      // Divide: bring the next dividend bit into the partial remainder and trial-subtract
      shifted = {acc_i[2*XLEN-1:XLEN], acc_i[XLEN-1]};
      fits    = (shifted >= {1'b0, oper_i});
      diff    = shifted[XLEN-1:0] - oper_i;

      acc_o = {sum, acc_i[XLEN-1:1]};
      if (is_div_i) begin
         if (fits) begin
            acc_o = {diff, acc_i[XLEN-2:0], 1'b1};
         end else begin
            acc_o = {shifted[XLEN-1:0], acc_i[XLEN-2:0], 1'b0};
         end
      end
   end

endmodule

// File: rtl/execute_mul_div_unit.sv
// Iterative RV32M multiply/divide unit sitting beside the ALU in Execute.
//   clk, reset         : clock, synchronous active-high reset
//   start, flush       : op request (IDLE only) and pipeline squash
//   funct3             : RV32M operation select
//   operand1, operand2 : rs1 value and ALU input-2 mux value
//   busy               : op in flight, drives the IF/ID/EX stall
//   done, result       : one-cycle completion pulse and registered result
module execute_mul_div_unit
   import mul_div_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic            flush,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] operand1,
   input  logic [XLEN-1:0] operand2,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   localparam int unsigned     CNTW      = 6;
   localparam logic [CNTW-1:0] LAST_ITER = CNTW'(XLEN - 1);

   state_e              state_q;
   logic [CNTW-1:0]     cnt_q;
   logic [2*XLEN-1:0]   acc_q;
   logic [2*XLEN-1:0]   acc_d;
   logic [XLEN-1:0]     oper_q;
   logic [2:0]          funct3_q;
   logic                neg_q;
   logic                sa_q;
   logic                special_q;
   logic [XLEN-1:0]     spec_res_q;
   logic                busy_q;
   logic                done_q;
   logic [XLEN-1:0]     result_q;

   logic                a_signed;
   logic                b_signed;
   logic                sign_a;
   logic                sign_b;
   logic [XLEN-1:0]     mag_a;
   logic [XLEN-1:0]     mag_b;
   logic                div_zero;
   logic                div_ovf;
   logic [XLEN-1:0]     special_res;

   logic [2*XLEN-1:0]   prod;
   logic [XLEN-1:0]     quo;
   logic [XLEN-1:0]     rem;
   logic [XLEN-1:0]     fin_res;

   mul_div_step #(.XLEN(XLEN)) u_step (
      .is_div_i (funct3_q[2]),
      .acc_i    (acc_q),
      .oper_i   (oper_q),
      .acc_o    (acc_d)
   );

   // Request decode: operand signedness, magnitudes and the no-iteration divide cases
   always_comb begin
      a_signed = (funct3 == F3_MUL) || (funct3 == F3_MULH) || (funct3 == F3_MULHSU) ||
                 (funct3 == F3_DIV) || (funct3 == F3_REM);
      b_signed = (funct3 == F3_MUL) || (funct3 == F3_MULH) ||
                 (funct3 == F3_DIV) || (funct3 == F3_REM);
      sign_a   = a_signed & operand1[XLEN-1];
      sign_b   = b_signed & operand2[XLEN-1];
      mag_a    = sign_a ? -operand1 : operand1;
      mag_b    = sign_b ? -operand2 : operand2;
      div_zero = funct3[2] && (operand2 == '0);
      div_ovf  = ((funct3 == F3_DIV) || (funct3 == F3_REM)) &&
                 (operand1 == {1'b1, {(XLEN-1){1'b0}}}) && (operand2 == '1);
      special_res = '0;
      if (div_zero) begin
         special_res = funct3[1] ? operand1 : '1;
      end else if (div_ovf) begin
         special_res = funct3[1] ? '0 : operand1;
      end
   end

   // Sign fix-up and half/quotient/remainder selection on the finished accumulator
   always_comb begin
      prod = neg_q ? -acc_q : acc_q;
      quo  = acc_q[XLEN-1:0];
      rem  = acc_q[2*XLEN-1:XLEN];
      if (special_q) begin
         fin_res = spec_res_q;
      end else if (!funct3_q[2]) begin
         fin_res = (funct3_q == F3_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
      end else if (funct3_q[1]) begin
         fin_res = sa_q ? -rem : rem;
      end else begin
         fin_res = neg_q ? -quo : quo;
      end
   end

   // Sequencer, operand latches and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         acc_q      <= '0;
         oper_q     <= '0;
         funct3_q   <= '0;
         neg_q      <= 1'b0;
         sa_q       <= 1'b0;
         special_q  <= 1'b0;
         spec_res_q <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         result_q   <= '0;
      end else begin
         done_q <= 1'b0;
         if (flush) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
         end else begin
            case (state_q)
               IDLE: begin
                  if (start) begin
                     funct3_q   <= funct3;
                     neg_q      <= sign_a ^ sign_b;
                     sa_q       <= sign_a;
                     special_q  <= div_zero | div_ovf;
                     spec_res_q <= special_res;
                     // Divide iterates on the dividend, multiply shifts the multiplier out of lo
                     acc_q      <= {{XLEN{1'b0}}, (funct3[2] ? mag_a : mag_b)};
                     oper_q     <= funct3[2] ? mag_b : mag_a;
                     cnt_q      <= '0;
                     busy_q     <= 1'b1;
                     state_q    <= (div_zero | div_ovf) ? DONE : ITER;
                  end
               end
               ITER: begin
                  acc_q <= acc_d;
                  if (cnt_q == LAST_ITER) begin
                     cnt_q   <= '0;
                     state_q <= DONE;
                  end else begin
                     cnt_q <= cnt_q + CNTW'(1);
                  end
               end
               DONE: begin
                  result_q <= fin_res;
                  done_q   <= 1'b1;
                  busy_q   <= 1'b0;
                  state_q  <= IDLE;
               end
               default: begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign result = result_q;

endmodule

// File: tb/tb_execute_mul_div_unit.sv
// Self-checking bench for execute_mul_div_unit: behavioural RV32M model with a
// latency countdown, per-cycle output compare, directed literal cases, random traffic.
module tb_execute_mul_div_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        flush = 1'b0;
   logic [2:0]  funct3 = 3'd0;
   logic [31:0] operand1 = 32'd0;
   logic [31:0] operand2 = 32'd0;
   logic        busy;
   logic        done;
   logic [31:0] result;

   execute_mul_div_unit #(.XLEN(32)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .flush    (flush),
      .funct3   (funct3),
      .operand1 (operand1),
      .operand2 (operand2),
      .busy     (busy),
      .done     (done),
      .result   (result)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_en  = 1'b0;

   // Directed expectations published by the stimulus process
   bit          lit_valid = 1'b0;
   logic [31:0] lit_res   = 32'd0;
   int          lit_lat   = 0;
   string       lit_name  = "";
   int          tmo_count = 0;
   int          tmo_seen  = 0;

   // Architectural result of one RV32M op
   function automatic logic [31:0] ref_res(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] sa64;
      logic [63:0] sb64;
      logic [63:0] ua64;
      logic [63:0] ub64;
      logic [63:0] p;
      int          ia;
      int          ib;
      bit          ovf;
      sa64 = {{32{a[31]}}, a};
      sb64 = {{32{b[31]}}, b};
      ua64 = {32'd0, a};
      ub64 = {32'd0, b};
      ia   = a;
      ib   = b;
      ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      case (f)
         3'd0: begin p = ua64 * ub64; return p[31:0];  end
         3'd1: begin p = sa64 * sb64; return p[63:32]; end
         3'd2: begin p = sa64 * ub64; return p[63:32]; end
         3'd3: begin p = ua64 * ub64; return p[63:32]; end
         3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(ia / ib);
         3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'd6: return (b == 0) ? a : ovf ? 32'd0 : 32'(ia % ib);
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   function automatic bit is_special(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      if (!f[2]) return 1'b0;
      if (b == 0) return 1'b1;
      return (f == 3'd4 || f == 3'd6) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
   endfunction

   // Behavioural model: countdown of edges until completion
   int          m_rem  = 0;
   int          m_lat  = 0;
   logic        m_busy = 1'b0;
   logic        m_done = 1'b0;
   logic [31:0] m_res  = 32'd0;
   logic [31:0] m_pend = 32'd0;

   always @(posedge clk) begin
      if (reset) begin
         m_rem = 0; m_lat = 0; m_busy = 1'b0; m_done = 1'b0; m_res = 32'd0;
      end else begin
         m_done = 1'b0;
         if (flush) begin
            m_rem  = 0;
            m_busy = 1'b0;
         end else if (m_rem == 0) begin
            if (start) begin
               m_pend = ref_res(funct3, operand1, operand2);
               m_rem  = is_special(funct3, operand1, operand2) ? 1 : 33;
               m_lat  = 0;
               m_busy = 1'b1;
            end
         end else begin
            m_rem--;
            m_lat++;
            if (m_rem == 0) begin
               m_busy = 1'b0;
               m_done = 1'b1;
               m_res  = m_pend;
            end
         end
      end
   end

   // Single compare process: model outputs every cycle, plus literal pins on completion
   always @(negedge clk) begin
      if (chk_en) begin
         n_tests++;
         if (busy !== m_busy) begin
            n_fail++;
            $display("FAIL busy @%0t: got %b want %b", $time, busy, m_busy);
         end
         n_tests++;
         if (done !== m_done) begin
            n_fail++;
            $display("FAIL done @%0t: got %b want %b", $time, done, m_done);
         end
         n_tests++;
         if (result !== m_res) begin
            n_fail++;
            $display("FAIL result @%0t: got %h want %h", $time, result, m_res);
         end
         if (lit_valid && (done || m_done)) begin
            n_tests++;
            if (result !== lit_res) begin
               n_fail++;
               $display("FAIL %s result: got %h want %h", lit_name, result, lit_res);
            end
            n_tests++;
            if (m_lat != lit_lat || done !== 1'b1) begin
               n_fail++;
               $display("FAIL %s latency: got %0d (done=%b) want %0d", lit_name, m_lat, done, lit_lat);
            end
         end
         if (tmo_count != tmo_seen) begin
            n_tests++;
            n_fail++;
            $display("FAIL timeout waiting for done (%0d)", tmo_count);
            tmo_seen = tmo_count;
         end
      end
   end

   function automatic logic [31:0] rnd_op();
      case ($urandom_range(0, 7))
         0: return 32'd0;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'd1;
         default: return $urandom;
      endcase
   endfunction

   // Issue one op with a literal expectation; optionally pulse start again mid-op
   task automatic do_op(input string nm, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] er, input int el, input int pulse_at);
      int n;
      @(negedge clk);
      funct3 = f; operand1 = a; operand2 = b; start = 1'b1;
      lit_name = nm; lit_res = er; lit_lat = el; lit_valid = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (!done && n < 100) begin
         if (n == pulse_at) begin
            start = 1'b1; funct3 = 3'd5; operand1 = $urandom; operand2 = 32'd3;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         n++;
      end
      start = 1'b0;
      if (!done) tmo_count++;
      @(negedge clk);
      lit_valid = 1'b0;
   endtask

   initial begin
      repeat (2) @(negedge clk);
      chk_en = 1'b1;
      @(negedge clk);
      reset = 1'b0;

      do_op("mul_7_m3",     3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, -1);
      do_op("mulhu_max",    3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, -1);
      do_op("mulh_min",     3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 33, -1);
      do_op("mulhsu_m1",    3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, -1);
      do_op("div_m7_2",     3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33, -1);
      do_op("rem_m7_2",     3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33, -1);
      do_op("divu_100_7",   3'd5, 32'd100,        32'd7,         32'd14,        33, -1);
      do_op("remu_100_7",   3'd7, 32'd100,        32'd7,         32'd2,         33, -1);
      do_op("divu_by0",     3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF, 1,  -1);
      do_op("rem_by0",      3'd6, 32'd5,          32'd0,         32'd5,         1,  -1);
      do_op("div_ovf",      3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1,  -1);
      do_op("rem_ovf",      3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1,  -1);
      do_op("mul_start_mid",3'd0, 32'd5,          32'd6,         32'd30,        33, 5);

      // Flush around iteration 10: op must vanish without a done pulse
      @(negedge clk);
      funct3 = 3'd0; operand1 = 32'h0001_2345; operand2 = 32'h777; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      repeat (40) @(negedge clk);
      do_op("mul_after_flush", 3'd0, 32'd3, 32'd4, 32'd12, 33, -1);

      // Flush and start together in IDLE: not accepted
      @(negedge clk);
      funct3 = 3'd3; operand1 = 32'd9; operand2 = 32'd9; start = 1'b1; flush = 1'b1;
      @(negedge clk);
      start = 1'b0; flush = 1'b0;
      repeat (3) @(negedge clk);

      // Reset at iteration 5 behaves like power-on
      funct3 = 3'd1; operand1 = $urandom; operand2 = $urandom; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      repeat (3) @(negedge clk);

      // Random traffic including back-to-back starts, flushes and rare resets
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         start    = ($urandom_range(0, 5) == 0);
         flush    = ($urandom_range(0, 60) == 0);
         reset    = ($urandom_range(0, 800) == 0);
         funct3   = 3'($urandom_range(0, 7));
         operand1 = rnd_op();
         operand2 = rnd_op();
      end
      @(negedge clk);
      start = 1'b0; flush = 1'b0; reset = 1'b0;
      repeat (40) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
